// File: rtl/adder_pkg.sv
// Shared constants and FSM encoding for the nibble-serial adder.
// Also holds the counter-width helper so every user sizes the counter the same way.
package adder_pkg;

    localparam int unsigned NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // A single-nibble operand still needs a 1-bit counter.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cla4_slice.sv
// 4-bit carry-lookahead adder slice with carry-in.
// Exposes the carry into bit 3 so the top slice can derive signed overflow.
module cla4_slice
    import adder_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             cin,
    output logic [NIB_W-1:0] sum,
    output logic             c3,
    output logic             cout
);

    logic [NIB_W-1:0] g;
    logic [NIB_W-1:0] p;
    logic [NIB_W-1:0] c;

    assign g = a & b;
    assign p = a ^ b;

    // Every carry is a flat sum of products of g/p and cin: no ripple path.
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);

    assign cout = g[3]
                | (p[3] & g[2])
                | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);

    assign sum = p ^ c;
    assign c3  = c[3];

endmodule

// File: rtl/nibble_serial_adder.sv
// Adds two W-bit operands one nibble per clock through a single CLA slice.
// Handshaked on both sides; the result is held in DONE until the consumer takes it.
module nibble_serial_adder
    import adder_pkg::*;
#(
    parameter int unsigned N_NIB = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NIB_W*N_NIB-1:0]   a,
    input  logic [NIB_W*N_NIB-1:0]   b,
    input  logic                     cin,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NIB_W*N_NIB-1:0]   sum,
    output logic                     cout,
    output logic                     ovf
);

    localparam int unsigned W  = NIB_W * N_NIB;
    localparam int unsigned CW = cnt_width(N_NIB);
    localparam logic [CW-1:0] LAST = CW'(N_NIB - 1);

    state_e state_q, state_d;

    logic [W-1:0]  a_q, b_q, sum_q;
    logic [CW-1:0] cnt_q;
    logic          carry_q, cout_q, ovf_q;

    logic             accept, step, last;
    logic [NIB_W-1:0] a_nib, b_nib, nib_sum;
    logic             nib_c3, nib_cout;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        step      = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept  = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                step = 1'b1;
                if (last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign last  = (cnt_q == LAST);
    assign a_nib = a_q[cnt_q*NIB_W +: NIB_W];
    assign b_nib = b_q[cnt_q*NIB_W +: NIB_W];

    cla4_slice u_slice (
        .a    (a_nib),
        .b    (b_nib),
        .cin  (carry_q),
        .sum  (nib_sum),
        .c3   (nib_c3),
        .cout (nib_cout)
    );

    // Datapath: operands latched on accept; result fields only move while BUSY.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            cnt_q   <= '0;
        end else if (step) begin
            sum_q[cnt_q*NIB_W +: NIB_W] <= nib_sum;
            carry_q <= nib_cout;
            cnt_q   <= cnt_q + 1'b1;
            if (last) begin
                cout_q <= nib_cout;
                ovf_q  <= nib_c3 ^ nib_cout;
            end
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench: directed vector table, stall/reset sequences and a
// randomized run checked against plain a + b + cin arithmetic.
module tb_nibble_serial_adder;

    localparam int unsigned N_NIB = 4;
    localparam int unsigned W     = 4 * N_NIB;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int n_cmp  = 0;
    int n_fail = 0;

    nibble_serial_adder #(.N_NIB(N_NIB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: the full-width arithmetic sum; overflow from operand/result signs.
    task automatic ref_add(input logic [W-1:0] ra, input logic [W-1:0] rb, input logic rc,
                           output logic [W-1:0] rs, output logic rco, output logic rov);
        logic [W:0] full;
        full = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
        rs   = full[W-1:0];
        rco  = full[W];
        rov  = (ra[W-1] == rb[W-1]) && (rs[W-1] != ra[W-1]);
    endtask

    task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                            input int gap);
        in_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        a        = ta;
        b        = tb_;
        cin      = tc;
        in_valid = 1'b1;
        check("in_ready_idle", W'(in_ready), W'(1));
        @(posedge clk);
    endtask

    // Called on the acceptance edge; measures latency, checks the result, stalls, releases.
    task automatic finish_op(input logic [W-1:0] es, input logic ec, input logic eo,
                             input int hold);
        int cyc;
        cyc = 0;
        #1;
        in_valid = 1'b0;
        a        = W'($urandom);
        b        = W'($urandom);
        cin      = 1'($urandom);
        for (int i = 1; i <= 50; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                cyc = i;
                break;
            end
        end
        check("latency", W'(cyc), W'(N_NIB));
        check("sum", sum, es);
        check("cout", W'(cout), W'(ec));
        check("ovf", W'(ovf), W'(eo));
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom);
            a        = W'($urandom);
            b        = W'($urandom);
            @(posedge clk);
            #1;
            check("hold_out_valid", W'(out_valid), W'(1));
            check("hold_in_ready", W'(in_ready), W'(0));
            check("hold_sum", sum, es);
            check("hold_cout", W'(cout), W'(ec));
            check("hold_ovf", W'(ovf), W'(eo));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("release_out_valid", W'(out_valid), W'(0));
        check("release_in_ready", W'(in_ready), W'(1));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0] ra, rb, rs;
        logic         rc, rco, rov;

        vecs[0] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};
        vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[5] = '{16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0};
        vecs[6] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[7] = '{16'h4000, 16'h4000, 1'b0, 16'h8000, 1'b0, 1'b1};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;

        #2;
        check("rst_in_ready", W'(in_ready), W'(1));
        check("rst_out_valid", W'(out_valid), W'(0));
        check("rst_sum", sum, '0);
        check("rst_cout", W'(cout), W'(0));
        check("rst_ovf", W'(ovf), W'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_no_accept", W'(in_ready), W'(1));

        // Directed vectors
        foreach (vecs[i]) begin
            start_op(vecs[i].a, vecs[i].b, vecs[i].cin, i % 3);
            finish_op(vecs[i].sum, vecs[i].cout, vecs[i].ovf, i % 2);
        end

        // Long consumer stall with in_valid pulses ignored
        start_op(16'h7FFF, 16'h0001, 1'b0, 0);
        finish_op(16'h8000, 1'b0, 1'b1, 10);

        // Reset during the second BUSY cycle abandons the operation
        start_op(16'h1234, 16'h4321, 1'b1, 0);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", W'(in_ready), W'(1));
        check("midrst_out_valid", W'(out_valid), W'(0));
        check("midrst_sum", sum, '0);
        check("midrst_cout", W'(cout), W'(0));
        check("midrst_ovf", W'(ovf), W'(0));
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("inrst_out_valid", W'(out_valid), W'(0));
        end
        a        = 16'hABCD;
        b        = 16'h1111;
        cin      = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        finish_op(16'hBCDE, 1'b0, 1'b0, 0);

        // Randomized operands with random handshake gaps
        for (int n = 0; n < 1000; n++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            if (n % 10 == 0) rb = ~ra;
            ref_add(ra, rb, rc, rs, rco, rov);
            start_op(ra, rb, rc, int'($urandom_range(0, 3)));
            finish_op(rs, rco, rov, int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
